// File: rtl/snes_rom_sequencer.sv
`default_nettype none
// snes_rom_sequencer: times decoded SNES (and optional MCU) accesses onto a shared 16-bit ROM/SaveRAM
// with fixed wait states. Define MCU_PORT_EN to enable the MCU request path; SNES always wins arbitration.
module snes_rom_sequencer #(
  parameter int RD_CYCLES = 6,
  parameter int WR_CYCLES = 6
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SNES_RD_start,
  input  logic        SNES_WR_start,
  input  logic [23:0] ROM_ADDR,
  input  logic        ROM_HIT,
  input  logic        IS_WRITABLE,
  input  logic [7:0]  SNES_DATA_IN,
  output logic [7:0]  SNES_DATA_OUT,
  output logic        SNES_RD_VALID,
  input  logic        MCU_RRQ,
  input  logic        MCU_WRQ,
  input  logic [23:0] MCU_ADDR,
  input  logic [7:0]  MCU_DOUT,
  output logic [7:0]  MCU_DINr,
  output logic        MCU_RDY,
  output logic [22:0] MEM_ADDR,
  output logic        MEM_CE_N,
  output logic        MEM_OE_N,
  output logic        MEM_WE_N,
  output logic        MEM_BHE_N,
  output logic        MEM_BLE_N,
  output logic [15:0] MEM_DQ_OUT,
  output logic        MEM_DQ_OE,
  input  logic [15:0] MEM_DQ_IN
);

  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_HOLD = CNT_W'(WR_CYCLES - 2);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

`ifdef MCU_PORT_EN
  typedef enum logic [2:0] {IDLE, SNES_RD, SNES_WR, MCU_RD, MCU_WR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SNES_RD, SNES_WR} state_t;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             op_lsb, op_lsb_nxt;
  logic             op_done;
  logic [22:0]      mem_addr, mem_addr_nxt;
  logic             ce_n, ce_n_nxt, oe_n, oe_n_nxt, we_n, we_n_nxt;
  logic             bhe_n, bhe_n_nxt, ble_n, ble_n_nxt;
  logic [15:0]      dq_out, dq_out_nxt;
  logic             dq_oe, dq_oe_nxt;
  logic [7:0]       snes_dout, snes_dout_nxt;
  logic             snes_vld, snes_vld_nxt;
  logic             snes_pv, snes_pv_nxt, snes_prd, snes_prd_nxt;
  logic [23:0]      snes_paddr, snes_paddr_nxt;
  logic [7:0]       snes_pdata, snes_pdata_nxt;

  // Pulses that miss external memory, or write to read-only space, never reach the pending latch.
  logic        snes_new, snes_req, snes_req_rd;
  logic [23:0] snes_req_addr;
  logic [7:0]  snes_req_data;
  assign snes_new      = (SNES_RD_start | SNES_WR_start) & ROM_HIT & (SNES_RD_start | IS_WRITABLE);
  assign snes_req      = snes_new | snes_pv;
  assign snes_req_rd   = snes_new ? SNES_RD_start : snes_prd;
  assign snes_req_addr = snes_new ? ROM_ADDR : snes_paddr;
  assign snes_req_data = snes_new ? SNES_DATA_IN : snes_pdata;

  logic        mcu_req, mcu_req_rd;
  logic [23:0] mcu_req_addr;
  logic [7:0]  mcu_req_data;
`ifdef MCU_PORT_EN
  logic        mcu_new;
  logic        mcu_pv, mcu_pv_nxt, mcu_prd, mcu_prd_nxt;
  logic [23:0] mcu_paddr, mcu_paddr_nxt;
  logic [7:0]  mcu_pdata, mcu_pdata_nxt;
  logic [7:0]  mcu_din, mcu_din_nxt;
  logic        mcu_rdy, mcu_rdy_nxt;
  assign mcu_new      = MCU_RRQ | MCU_WRQ;
  assign mcu_req      = mcu_new | mcu_pv;
  assign mcu_req_rd   = mcu_new ? MCU_RRQ : mcu_prd;
  assign mcu_req_addr = mcu_new ? MCU_ADDR : mcu_paddr;
  assign mcu_req_data = mcu_new ? MCU_DOUT : mcu_pdata;
  assign MCU_DINr     = mcu_din;
  assign MCU_RDY      = mcu_rdy;
`else
  logic unused_mcu;
  assign unused_mcu   = ^{MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT};
  assign mcu_req      = 1'b0;
  assign mcu_req_rd   = 1'b0;
  assign mcu_req_addr = 24'h000000;
  assign mcu_req_data = 8'h00;
  assign MCU_DINr     = 8'h00;
  assign MCU_RDY      = 1'b0;
`endif

  logic        sel_rd;
  logic [23:0] sel_addr;
  logic [7:0]  sel_data, rd_byte;
  assign sel_rd   = snes_req ? snes_req_rd   : mcu_req_rd;
  assign sel_addr = snes_req ? snes_req_addr : mcu_req_addr;
  assign sel_data = snes_req ? snes_req_data : mcu_req_data;
  assign rd_byte  = op_lsb ? MEM_DQ_IN[15:8] : MEM_DQ_IN[7:0];

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    op_lsb_nxt     = op_lsb;
    op_done        = 1'b0;
    mem_addr_nxt   = mem_addr;
    ce_n_nxt       = ce_n;
    oe_n_nxt       = oe_n;
    we_n_nxt       = we_n;
    bhe_n_nxt      = bhe_n;
    ble_n_nxt      = ble_n;
    dq_out_nxt     = dq_out;
    dq_oe_nxt      = dq_oe;
    snes_dout_nxt  = snes_dout;
    snes_vld_nxt   = 1'b0;
    snes_pv_nxt    = snes_pv;
    snes_prd_nxt   = snes_prd;
    snes_paddr_nxt = snes_paddr;
    snes_pdata_nxt = snes_pdata;
    if (snes_new) begin
      snes_pv_nxt    = 1'b1;
      snes_prd_nxt   = SNES_RD_start;
      snes_paddr_nxt = ROM_ADDR;
      snes_pdata_nxt = SNES_DATA_IN;
    end
`ifdef MCU_PORT_EN
    mcu_pv_nxt    = mcu_pv;
    mcu_prd_nxt   = mcu_prd;
    mcu_paddr_nxt = mcu_paddr;
    mcu_pdata_nxt = mcu_pdata;
    mcu_din_nxt   = mcu_din;
    mcu_rdy_nxt   = 1'b0;
    if (mcu_new) begin
      mcu_pv_nxt    = 1'b1;
      mcu_prd_nxt   = MCU_RRQ;
      mcu_paddr_nxt = MCU_ADDR;
      mcu_pdata_nxt = MCU_DOUT;
    end
`endif

    case (state)
      IDLE: begin
        if (snes_req) begin
          state_nxt   = sel_rd ? SNES_RD : SNES_WR;
          snes_pv_nxt = 1'b0;
        end
`ifdef MCU_PORT_EN
        else if (mcu_req) begin
          state_nxt  = sel_rd ? MCU_RD : MCU_WR;
          mcu_pv_nxt = 1'b0;
        end
`endif
        if (snes_req || mcu_req) begin
          cnt_nxt      = '0;
          op_lsb_nxt   = sel_addr[0];
          mem_addr_nxt = sel_addr[23:1];
          ce_n_nxt     = 1'b0;
          if (sel_rd) begin
            oe_n_nxt  = 1'b0;
            bhe_n_nxt = 1'b0;
            ble_n_nxt = 1'b0;
          end else begin
            we_n_nxt   = 1'b0;
            dq_oe_nxt  = 1'b1;
            dq_out_nxt = {sel_data, sel_data};
            bhe_n_nxt  = ~sel_addr[0];
            ble_n_nxt  = sel_addr[0];
          end
        end
      end
      SNES_RD: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == RD_LAST) begin
          op_done       = 1'b1;
          snes_dout_nxt = rd_byte;
          snes_vld_nxt  = 1'b1;
        end
      end
      SNES_WR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == WR_HOLD) we_n_nxt = 1'b1;
        if (cnt == WR_LAST) op_done = 1'b1;
      end
`ifdef MCU_PORT_EN
      MCU_RD: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == RD_LAST) begin
          op_done     = 1'b1;
          mcu_din_nxt = rd_byte;
          mcu_rdy_nxt = 1'b1;
        end
      end
      MCU_WR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == WR_HOLD) we_n_nxt = 1'b1;
        if (cnt == WR_LAST) begin
          op_done     = 1'b1;
          mcu_rdy_nxt = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase

    if (op_done) begin
      state_nxt = IDLE;
      ce_n_nxt  = 1'b1;
      oe_n_nxt  = 1'b1;
      we_n_nxt  = 1'b1;
      bhe_n_nxt = 1'b1;
      ble_n_nxt = 1'b1;
      dq_oe_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      op_lsb     <= 1'b0;
      mem_addr   <= '0;
      ce_n       <= 1'b1;
      oe_n       <= 1'b1;
      we_n       <= 1'b1;
      bhe_n      <= 1'b1;
      ble_n      <= 1'b1;
      dq_out     <= '0;
      dq_oe      <= 1'b0;
      snes_dout  <= 8'h00;
      snes_vld   <= 1'b0;
      snes_pv    <= 1'b0;
      snes_prd   <= 1'b0;
      snes_paddr <= '0;
      snes_pdata <= '0;
`ifdef MCU_PORT_EN
      mcu_pv     <= 1'b0;
      mcu_prd    <= 1'b0;
      mcu_paddr  <= '0;
      mcu_pdata  <= '0;
      mcu_din    <= 8'h00;
      mcu_rdy    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      op_lsb     <= op_lsb_nxt;
      mem_addr   <= mem_addr_nxt;
      ce_n       <= ce_n_nxt;
      oe_n       <= oe_n_nxt;
      we_n       <= we_n_nxt;
      bhe_n      <= bhe_n_nxt;
      ble_n      <= ble_n_nxt;
      dq_out     <= dq_out_nxt;
      dq_oe      <= dq_oe_nxt;
      snes_dout  <= snes_dout_nxt;
      snes_vld   <= snes_vld_nxt;
      snes_pv    <= snes_pv_nxt;
      snes_prd   <= snes_prd_nxt;
      snes_paddr <= snes_paddr_nxt;
      snes_pdata <= snes_pdata_nxt;
`ifdef MCU_PORT_EN
      mcu_pv     <= mcu_pv_nxt;
      mcu_prd    <= mcu_prd_nxt;
      mcu_paddr  <= mcu_paddr_nxt;
      mcu_pdata  <= mcu_pdata_nxt;
      mcu_din    <= mcu_din_nxt;
      mcu_rdy    <= mcu_rdy_nxt;
`endif
    end
  end

  assign MEM_ADDR      = mem_addr;
  assign MEM_CE_N      = ce_n;
  assign MEM_OE_N      = oe_n;
  assign MEM_WE_N      = we_n;
  assign MEM_BHE_N     = bhe_n;
  assign MEM_BLE_N     = ble_n;
  assign MEM_DQ_OUT    = dq_out;
  assign MEM_DQ_OE     = dq_oe;
  assign SNES_DATA_OUT = snes_dout;
  assign SNES_RD_VALID = snes_vld;

endmodule
`default_nettype wire

// File: tb/tb_snes_rom_sequencer.sv
`default_nettype none
// tb_snes_rom_sequencer: directed and randomized checks of snes_rom_sequencer against a
// transaction-level model that tracks each memory op by its start cycle.
module tb_snes_rom_sequencer;
  localparam int RD_CYCLES = 6;
  localparam int WR_CYCLES = 6;
`ifdef MCU_PORT_EN
  localparam bit MCU_ON = 1'b1;
`else
  localparam bit MCU_ON = 1'b0;
`endif
  localparam int K_NONE = 0, K_SRD = 1, K_SWR = 2, K_MRD = 3, K_MWR = 4;

  logic clk = 1'b0;
  logic rst;
  logic snes_rd_start, snes_wr_start, rom_hit, is_writable;
  logic [23:0] rom_addr, mcu_addr;
  logic [7:0]  snes_data_in, snes_data_out, mcu_dout, mcu_dinr;
  logic snes_rd_valid, mcu_rrq, mcu_wrq, mcu_rdy;
  logic [22:0] mem_addr;
  logic mem_ce_n, mem_oe_n, mem_we_n, mem_bhe_n, mem_ble_n, mem_dq_oe;
  logic [15:0] mem_dq_out, mem_dq_in;

  snes_rom_sequencer #(.RD_CYCLES(RD_CYCLES), .WR_CYCLES(WR_CYCLES)) dut (
    .CLK(clk), .RST(rst),
    .SNES_RD_start(snes_rd_start), .SNES_WR_start(snes_wr_start),
    .ROM_ADDR(rom_addr), .ROM_HIT(rom_hit), .IS_WRITABLE(is_writable),
    .SNES_DATA_IN(snes_data_in), .SNES_DATA_OUT(snes_data_out), .SNES_RD_VALID(snes_rd_valid),
    .MCU_RRQ(mcu_rrq), .MCU_WRQ(mcu_wrq), .MCU_ADDR(mcu_addr), .MCU_DOUT(mcu_dout),
    .MCU_DINr(mcu_dinr), .MCU_RDY(mcu_rdy),
    .MEM_ADDR(mem_addr), .MEM_CE_N(mem_ce_n), .MEM_OE_N(mem_oe_n), .MEM_WE_N(mem_we_n),
    .MEM_BHE_N(mem_bhe_n), .MEM_BLE_N(mem_ble_n),
    .MEM_DQ_OUT(mem_dq_out), .MEM_DQ_OE(mem_dq_oe), .MEM_DQ_IN(mem_dq_in)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int t = 0;
  bit hold_dq = 1'b0;

  // Reference state: the current/last op as (kind, start cycle, addr, data) plus one pending slot per source.
  int m_kind, m_start;
  logic [23:0] m_addr;
  logic [7:0]  m_data;
  bit sp_v, sp_rd, mp_v, mp_rd;
  logic [23:0] sp_addr, mp_addr;
  logic [7:0]  sp_data, mp_data;
  logic [22:0] m_mem_addr;
  logic [7:0]  m_snes_out, m_mcu_out;
  bit m_vld, m_rdy;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  function automatic int op_len(input int kind);
    return (kind == K_SRD || kind == K_MRD) ? RD_CYCLES : WR_CYCLES;
  endfunction

  task automatic model_reset();
    m_kind = K_NONE; m_start = 0; m_addr = '0; m_data = '0;
    sp_v = 0; sp_rd = 0; sp_addr = '0; sp_data = '0;
    mp_v = 0; mp_rd = 0; mp_addr = '0; mp_data = '0;
    m_mem_addr = '0; m_snes_out = 8'h00; m_mcu_out = 8'h00; m_vld = 0; m_rdy = 0;
  endtask

  // Consumes the inputs of cycle t and predicts the outputs seen in cycle t+1.
  task automatic model_step();
    int len;
    bit idle;
    logic [7:0] b;
    m_vld = 0; m_rdy = 0;
    len = op_len(m_kind);
    if (m_kind != K_NONE && t == m_start + len - 1) begin
      b = m_addr[0] ? mem_dq_in[15:8] : mem_dq_in[7:0];
      if (m_kind == K_SRD) begin m_snes_out = b; m_vld = 1; end
      if (m_kind == K_MRD) begin m_mcu_out = b; m_rdy = 1; end
      if (m_kind == K_MWR) m_rdy = 1;
    end
    idle = (m_kind == K_NONE) || (t >= m_start + len);
    if ((snes_rd_start || snes_wr_start) && rom_hit && (snes_rd_start || is_writable)) begin
      sp_v = 1; sp_rd = snes_rd_start; sp_addr = rom_addr; sp_data = snes_data_in;
    end
    if (MCU_ON && (mcu_rrq || mcu_wrq)) begin
      mp_v = 1; mp_rd = mcu_rrq; mp_addr = mcu_addr; mp_data = mcu_dout;
    end
    if (idle && sp_v) begin
      m_kind = sp_rd ? K_SRD : K_SWR; m_addr = sp_addr; m_data = sp_data;
      m_start = t + 1; m_mem_addr = sp_addr[23:1]; sp_v = 0;
    end else if (idle && mp_v) begin
      m_kind = mp_rd ? K_MRD : K_MWR; m_addr = mp_addr; m_data = mp_data;
      m_start = t + 1; m_mem_addr = mp_addr[23:1]; mp_v = 0;
    end
  endtask

  task automatic compare_outputs();
    int len, k;
    bit act;
    logic [5:0] ec;
    len = op_len(m_kind);
    k = t - m_start;
    act = (m_kind != K_NONE) && (k >= 0) && (k < len);
    ec = 6'b111110;
    if (act && (m_kind == K_SRD || m_kind == K_MRD)) ec = 6'b001000;
    else if (act) ec = {1'b0, 1'b1, (k == len - 1), ~m_addr[0], m_addr[0], 1'b1};
    check_value("ctrl", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_bhe_n, mem_ble_n, mem_dq_oe}), 32'(ec));
    check_value("mem_addr", 32'(mem_addr), 32'(m_mem_addr));
    check_value("pulses", 32'({snes_rd_valid, mcu_rdy}), 32'({m_vld, m_rdy}));
    check_value("snes_out", 32'(snes_data_out), 32'(m_snes_out));
    check_value("mcu_out", 32'(mcu_dinr), 32'(m_mcu_out));
    if (ec[0]) check_value("dq_out", 32'(mem_dq_out), 32'({m_data, m_data}));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk); #1;
    t++;
    compare_outputs();
    snes_rd_start = 0; snes_wr_start = 0; mcu_rrq = 0; mcu_wrq = 0;
    if (!hold_dq) mem_dq_in = 16'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int oe_cnt, ce_cnt, we_cnt, vld_at, rdy_at;
    bit vld_seen;
    rst = 1; snes_rd_start = 0; snes_wr_start = 0; rom_hit = 1; is_writable = 0;
    rom_addr = '0; snes_data_in = '0; mcu_rrq = 0; mcu_wrq = 0; mcu_addr = '0; mcu_dout = '0;
    mem_dq_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_value("reset_ctrl", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_bhe_n, mem_ble_n, mem_dq_oe}), 32'(6'b111110));
    check_value("reset_addr", 32'(mem_addr), 32'h0);
    check_value("reset_pulses", 32'({snes_rd_valid, mcu_rdy}), 32'h0);
    check_value("reset_data", 32'({snes_data_out, mcu_dinr}), 32'h0);
    rst = 0;
    repeat (4) cycle();

    // SNES read of an odd byte address: high lane, 6 OE clocks, valid one clock later.
    hold_dq = 1; mem_dq_in = 16'hA55A; rom_hit = 1; rom_addr = 24'h008001; snes_rd_start = 1;
    oe_cnt = 0; vld_at = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (i == 1) check_value("rd_mem_addr", 32'(mem_addr), 32'h004000);
      if (!mem_oe_n) oe_cnt++;
      if (snes_rd_valid) vld_at = i;
    end
    check_value("rd_oe_clocks", 32'(oe_cnt), 32'(RD_CYCLES));
    check_value("rd_valid_at", 32'(vld_at), 32'(RD_CYCLES + 1));
    check_value("rd_byte", 32'(snes_data_out), 32'hA5);
    hold_dq = 0;

    // SaveRAM write to an even byte: low lane only, WE released one clock early.
    rom_addr = 24'hE00010; is_writable = 1; snes_data_in = 8'h3C; snes_wr_start = 1;
    ce_cnt = 0; we_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (i == 1) begin
        check_value("wr_lanes", 32'({mem_bhe_n, mem_ble_n}), 32'(2'b10));
        check_value("wr_dq", 32'(mem_dq_out), 32'h3C3C);
      end
      if (!mem_ce_n) ce_cnt++;
      if (!mem_we_n) we_cnt++;
    end
    check_value("wr_ce_clocks", 32'(ce_cnt), 32'(WR_CYCLES));
    check_value("wr_we_clocks", 32'(we_cnt), 32'(WR_CYCLES - 1));

    // Writes to read-only space and misses never touch memory.
    ce_cnt = 0;
    rom_addr = 24'hC00020; is_writable = 0; snes_wr_start = 1;
    for (int i = 1; i <= 4; i++) begin cycle(); if (!mem_ce_n) ce_cnt++; end
    rom_hit = 0; is_writable = 1; snes_wr_start = 1;
    for (int i = 1; i <= 4; i++) begin cycle(); if (!mem_ce_n) ce_cnt++; end
    snes_rd_start = 1;
    for (int i = 1; i <= 4; i++) begin cycle(); if (!mem_ce_n) ce_cnt++; end
    check_value("dropped_ce_clocks", 32'(ce_cnt), 32'h0);
    rom_hit = 1;

    // MCU read in flight when SNES arrives two clocks later.
    vld_at = 0; rdy_at = 0;
    mcu_addr = 24'h012345; mcu_rrq = 1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 3) begin rom_addr = 24'h00FFFE; snes_rd_start = 1; end
      cycle();
      if (snes_rd_valid && vld_at == 0) vld_at = i;
      if (mcu_rdy && rdy_at == 0) rdy_at = i;
    end
    check_value("mcu_first_rdy_at", 32'(rdy_at), MCU_ON ? 32'd7 : 32'd0);
    check_value("mcu_first_vld_at", 32'(vld_at), MCU_ON ? 32'd14 : 32'd9);

    // Simultaneous requests: SNES wins, MCU follows.
    vld_at = 0; rdy_at = 0;
    mcu_addr = 24'h200002; mcu_rrq = 1; rom_addr = 24'h400003; snes_rd_start = 1;
    for (int i = 1; i <= 16; i++) begin
      cycle();
      if (snes_rd_valid && vld_at == 0) vld_at = i;
      if (mcu_rdy && rdy_at == 0) rdy_at = i;
    end
    check_value("tie_vld_at", 32'(vld_at), 32'd7);
    check_value("tie_rdy_at", 32'(rdy_at), MCU_ON ? 32'd14 : 32'd0);

    // Randomized traffic from both sources.
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 5))
          0, 1, 2: snes_rd_start = 1;
          3, 4:    snes_wr_start = 1;
          default: begin snes_rd_start = 1; snes_wr_start = 1; end
        endcase
        rom_hit = ($urandom_range(0, 7) != 0);
        is_writable = 1'($urandom_range(0, 1));
        rom_addr = 24'($urandom);
        snes_data_in = 8'($urandom);
      end
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0) mcu_rrq = 1; else mcu_wrq = 1;
        mcu_addr = 24'($urandom);
        mcu_dout = 8'($urandom);
      end
      cycle();
    end
    repeat (30) cycle();

    // Reset in the middle of a SNES read.
    rom_hit = 1; rom_addr = 24'($urandom); snes_rd_start = 1;
    repeat (3) cycle();
    #3 rst = 1;
    #1;
    check_value("midop_rst_ctrl", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_bhe_n, mem_ble_n, mem_dq_oe}), 32'(6'b111110));
    check_value("midop_rst_addr", 32'(mem_addr), 32'h0);
    model_reset();
    vld_seen = 0;
    repeat (3) begin @(posedge clk); #1; if (snes_rd_valid) vld_seen = 1; end
    rst = 0;
    for (int i = 0; i < 10; i++) begin cycle(); if (snes_rd_valid) vld_seen = 1; end
    check_value("midop_no_valid", 32'(vld_seen), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
